// File: rtl/cnn_row_sequencer_pkg.sv
// Shared types and counter-width helpers for the CNN row sequencer and its egress serializer.
package cnn_seq_pkg;

  typedef enum logic {FILL, ISSUE} ingress_state_e;
  typedef enum logic {WAIT, DRAIN} egress_state_e;

  // Counter width that stays at least one bit for degenerate sizes
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_WIDTH  = 28;
  localparam int DEF_HEIGHT = 28;
  localparam int DEF_STRIDE = 1;

  localparam int COL_W  = cnt_w(DEF_WIDTH);
  localparam int ROW_W  = cnt_w(DEF_HEIGHT);
  localparam int BEAT_W = cnt_w(DEF_WIDTH / DEF_STRIDE);

endpackage

// File: rtl/cnn_row_sequencer_if.sv
// Stream and layer-row handshake bundle around the sequencer; master is the sequencer side.
interface cnn_row_sequencer_if #(
  parameter int VALUE_BITS   = 8,
  parameter int WIDTH        = 28,
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 2,
  parameter int STRIDE       = 1
);
  localparam int OUT_W = WIDTH / STRIDE;

  logic [IN_CHANNELS-1:0][VALUE_BITS-1:0]              in_pixel_i;
  logic                                                in_pixel_valid_i;
  logic                                                in_pixel_ready_o;
  logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0]   layer_row_o;
  logic                                                layer_row_valid_o;
  logic                                                layer_row_accept_i;
  logic                                                layer_row_last_o;
  logic [OUT_W-1:0][OUT_CHANNELS-1:0][VALUE_BITS-1:0]  layer_out_row_i;
  logic                                                layer_out_valid_i;
  logic                                                layer_out_accept_o;
  logic                                                layer_out_last_i;
  logic [OUT_CHANNELS-1:0][VALUE_BITS-1:0]             out_pixel_o;
  logic                                                out_pixel_valid_o;
  logic                                                out_pixel_ready_i;
  logic                                                out_pixel_last_o;
  logic                                                frame_done_o;

  modport master (
    input  in_pixel_i, in_pixel_valid_i, layer_row_accept_i,
    input  layer_out_row_i, layer_out_valid_i, layer_out_last_i, out_pixel_ready_i,
    output in_pixel_ready_o, layer_row_o, layer_row_valid_o, layer_row_last_o,
    output layer_out_accept_o, out_pixel_o, out_pixel_valid_o, out_pixel_last_o, frame_done_o
  );

  modport slave (
    output in_pixel_i, in_pixel_valid_i, layer_row_accept_i,
    output layer_out_row_i, layer_out_valid_i, layer_out_last_i, out_pixel_ready_i,
    input  in_pixel_ready_o, layer_row_o, layer_row_valid_o, layer_row_last_o,
    input  layer_out_accept_o, out_pixel_o, out_pixel_valid_o, out_pixel_last_o, frame_done_o
  );

endinterface

// File: rtl/cnn_row_sequencer_serializer.sv
// Egress side: captures one finished output row from the layer and plays it out pixel by pixel.
module cnn_row_serializer
  import cnn_seq_pkg::*;
#(
  parameter int VALUE_BITS   = 8,
  parameter int OUT_W        = 28,
  parameter int OUT_CHANNELS = 2
) (
  input  logic                                               clock_i,
  input  logic                                               reset_i,
  input  logic [OUT_W-1:0][OUT_CHANNELS-1:0][VALUE_BITS-1:0] row_i,
  input  logic                                               row_valid_i,
  input  logic                                               row_last_i,
  output logic                                               row_accept_o,
  output logic [OUT_CHANNELS-1:0][VALUE_BITS-1:0]            pixel_o,
  output logic                                               pixel_valid_o,
  input  logic                                               pixel_ready_i,
  output logic                                               pixel_last_o,
  output logic                                               frame_done_o
);

  localparam int BEAT_BITS = cnt_w(OUT_W);
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(OUT_W - 1);

  egress_state_e                                      state_q;
  logic                                               accept_q;
  logic                                               last_q;
  logic                                               done_q;
  logic [BEAT_BITS-1:0]                               beat_q;
  logic [OUT_W-1:0][OUT_CHANNELS-1:0][VALUE_BITS-1:0] obuf_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= WAIT;
      accept_q <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      beat_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        WAIT: begin
          accept_q <= 1'b1;
          if (row_valid_i && accept_q) begin
            obuf_q   <= row_i;
            last_q   <= row_last_i;
            beat_q   <= '0;
            accept_q <= 1'b0;
            state_q  <= DRAIN;
          end
        end
        DRAIN: begin
          if (pixel_ready_i) begin
            if (beat_q == LAST_BEAT) begin
              beat_q   <= '0;
              accept_q <= 1'b1;
              done_q   <= last_q;
              state_q  <= WAIT;
            end else begin
              beat_q <= beat_q + BEAT_BITS'(1);
            end
          end
        end
        default: state_q <= WAIT;
      endcase
    end
  end

  // The pixel mux only moves with beat_q, so data holds while the consumer stalls
  assign pixel_o       = obuf_q[beat_q];
  assign pixel_valid_o = (state_q == DRAIN);
  assign pixel_last_o  = (state_q == DRAIN) && last_q && (beat_q == LAST_BEAT);
  assign row_accept_o  = accept_q;
  assign frame_done_o  = done_q;

endmodule

// File: rtl/cnn_row_sequencer.sv
// Packs a pixel stream into layer rows and serializes layer output rows back to pixels.
// Define CNN_SEQ_DOUBLE_BUFFER_EN for ping/pong ingress row buffers.
module cnn_row_sequencer
  import cnn_seq_pkg::*;
#(
  parameter int VALUE_BITS   = 8,
  parameter int WIDTH        = 28,
  parameter int HEIGHT       = 28,
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 2,
  parameter int STRIDE       = 1
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  cnn_row_sequencer_if.master  bus
);

  localparam int OUT_W     = WIDTH / STRIDE;
  localparam int COL_BITS  = cnt_w(WIDTH);
  localparam int ROW_BITS  = cnt_w(HEIGHT);
`ifdef CNN_SEQ_DOUBLE_BUFFER_EN
  localparam int NBUF      = 2;
`else
  localparam int NBUF      = 1;
`endif
  localparam int SEL_BITS  = cnt_w(NBUF);

  typedef logic [WIDTH-1:0][IN_CHANNELS-1:0][VALUE_BITS-1:0] row_t;

  ingress_state_e       state_q;
  logic                 in_ready_q;
  logic [NBUF-1:0]      full_q, full_d;
  logic [SEL_BITS-1:0]  wr_sel_q, wr_sel_d;
  logic [SEL_BITS-1:0]  rd_sel_q, rd_sel_d;
  logic [COL_BITS-1:0]  col_q, col_d;
  logic [ROW_BITS-1:0]  row_cnt_q, row_cnt_d;
  row_t                 row_buf_q [NBUF];
  logic                 in_fire;
  logic                 issue_fire;

  assign in_fire    = bus.in_pixel_valid_i && in_ready_q;
  assign issue_fire = (state_q == ISSUE) && bus.layer_row_accept_i;

  // Rows issue in fill order, so the issued-row counter is also the issuing buffer's row index
  always_comb begin
    full_d    = full_q;
    wr_sel_d  = wr_sel_q;
    rd_sel_d  = rd_sel_q;
    col_d     = col_q;
    row_cnt_d = row_cnt_q;
    if (in_fire) begin
      if (col_q == COL_BITS'(WIDTH - 1)) begin
        col_d            = '0;
        full_d[wr_sel_q] = 1'b1;
        wr_sel_d         = (wr_sel_q == SEL_BITS'(NBUF - 1)) ? '0 : wr_sel_q + SEL_BITS'(1);
      end else begin
        col_d = col_q + COL_BITS'(1);
      end
    end
    if (issue_fire) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = (rd_sel_q == SEL_BITS'(NBUF - 1)) ? '0 : rd_sel_q + SEL_BITS'(1);
      row_cnt_d        = (row_cnt_q == ROW_BITS'(HEIGHT - 1)) ? '0 : row_cnt_q + ROW_BITS'(1);
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= FILL;
      in_ready_q <= 1'b0;
      full_q     <= '0;
      wr_sel_q   <= '0;
      rd_sel_q   <= '0;
      col_q      <= '0;
      row_cnt_q  <= '0;
    end else begin
      state_q    <= full_d[rd_sel_d] ? ISSUE : FILL;
      in_ready_q <= ~(&full_d);
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      col_q      <= col_d;
      row_cnt_q  <= row_cnt_d;
    end
  end

  // Row storage carries no reset; a partial row is simply overwritten from column 0
  always_ff @(posedge clock_i) begin
    if (in_fire) begin
      row_buf_q[wr_sel_q][col_q] <= bus.in_pixel_i;
    end
  end

  assign bus.in_pixel_ready_o  = in_ready_q;
  assign bus.layer_row_o       = row_buf_q[rd_sel_q];
  assign bus.layer_row_valid_o = (state_q == ISSUE);
  assign bus.layer_row_last_o  = (state_q == ISSUE) && (row_cnt_q == ROW_BITS'(HEIGHT - 1));

  cnn_row_serializer #(
    .VALUE_BITS   (VALUE_BITS),
    .OUT_W        (OUT_W),
    .OUT_CHANNELS (OUT_CHANNELS)
  ) u_serializer (
    .clock_i       (clock_i),
    .reset_i       (reset_i),
    .row_i         (bus.layer_out_row_i),
    .row_valid_i   (bus.layer_out_valid_i),
    .row_last_i    (bus.layer_out_last_i),
    .row_accept_o  (bus.layer_out_accept_o),
    .pixel_o       (bus.out_pixel_o),
    .pixel_valid_o (bus.out_pixel_valid_o),
    .pixel_ready_i (bus.out_pixel_ready_i),
    .pixel_last_o  (bus.out_pixel_last_o),
    .frame_done_o  (bus.frame_done_o)
  );

endmodule

// File: tb/tb_cnn_row_sequencer.sv
// Directed bench for cnn_row_sequencer: ingress packing, backpressure, egress serialization, reset.
module tb_cnn_row_sequencer;

  logic clock_i = 1'b0;
  logic reset_i;
  int   total = 0;
  int   bad   = 0;

  always #5 clock_i = ~clock_i;

  cnn_row_sequencer_if ifc ();

  cnn_row_sequencer dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .bus     (ifc.master)
  );

  // Passive record of every row issue the layer accepts
  int          n_iss;
  logic [7:0]  iss_p0   [64];
  logic [7:0]  iss_p5   [64];
  logic        iss_last [64];
  longint      iss_t    [64];

  always @(posedge clock_i) begin
    if (reset_i) begin
      n_iss <= 0;
    end else if (ifc.layer_row_valid_o && ifc.layer_row_accept_i) begin
      if (n_iss < 64) begin
        iss_p0[n_iss]   <= ifc.layer_row_o[0][0];
        iss_p5[n_iss]   <= ifc.layer_row_o[5][0];
        iss_last[n_iss] <= ifc.layer_row_last_o;
        iss_t[n_iss]    <= longint'($time);
      end
      n_iss <= n_iss + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge after the handshake or after the cycle bound
  task automatic send_px(input logic [7:0] v, input int bound, output bit ok);
    ifc.in_pixel_i[0]     = v;
    ifc.in_pixel_valid_i  = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < bound; c++) begin
      if (ifc.in_pixel_ready_o) begin
        @(negedge clock_i);
        ok = 1'b1;
        break;
      end
      @(negedge clock_i);
    end
    ifc.in_pixel_valid_i = 1'b0;
  endtask

  task automatic send_frame(input int n, output int stalls);
    bit ok;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      send_px(8'(i % 256), 50, ok);
      if (!ok) stalls++;
    end
  endtask

  task automatic egress_row(input bit lastf, output int beats, output int lasts, output int dones,
                            output bit order_ok, output bit hold_ok, output bit acc_ok,
                            output bit first_ok);
    bit         r;
    bit         prev_stall;
    bit         got;
    logic [15:0] prev_pix;
    beats = 0; lasts = 0; dones = 0;
    order_ok = 1'b1; hold_ok = 1'b1; acc_ok = 1'b1; first_ok = 1'b0;
    for (int b = 0; b < 28; b++) begin
      ifc.layer_out_row_i[b][0] = 8'(b);
      ifc.layer_out_row_i[b][1] = 8'(b + 100);
    end
    ifc.layer_out_last_i  = lastf;
    ifc.layer_out_valid_i = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (ifc.layer_out_accept_o) begin
        @(negedge clock_i);
        got = 1'b1;
        break;
      end
      @(negedge clock_i);
    end
    ifc.layer_out_valid_i = 1'b0;
    first_ok   = got && ifc.out_pixel_valid_o;
    r          = 1'b1;
    prev_stall = 1'b0;
    prev_pix   = '0;
    for (int c = 0; c < 120; c++) begin
      ifc.out_pixel_ready_i = r;
      if (ifc.frame_done_o) dones++;
      if (ifc.out_pixel_valid_o) begin
        if (ifc.layer_out_accept_o) acc_ok = 1'b0;
        if (prev_stall && (ifc.out_pixel_o !== prev_pix)) hold_ok = 1'b0;
        if (r) begin
          if (ifc.out_pixel_o[0] !== 8'(beats) || ifc.out_pixel_o[1] !== 8'(beats + 100))
            order_ok = 1'b0;
          if (ifc.out_pixel_last_o) begin
            lasts++;
            if (beats != 27) order_ok = 1'b0;
          end
          beats++;
        end
        prev_stall = !r;
        prev_pix   = ifc.out_pixel_o;
      end else begin
        prev_stall = 1'b0;
      end
      @(negedge clock_i);
      r = !r;
    end
    ifc.out_pixel_ready_i = 1'b0;
  endtask

  initial begin
    int   stalls;
    int   nl;
    int   acc;
    bit   ok;
    int   beats, lasts, dones;
    bit   order_ok, hold_ok, acc_ok, first_ok;
    logic [27:0][0:0][7:0] snap;

    reset_i                = 1'b1;
    ifc.in_pixel_i         = '0;
    ifc.in_pixel_valid_i   = 1'b0;
    ifc.layer_row_accept_i = 1'b0;
    ifc.layer_out_row_i    = '0;
    ifc.layer_out_valid_i  = 1'b0;
    ifc.layer_out_last_i   = 1'b0;
    ifc.out_pixel_ready_i  = 1'b0;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;

    // Reset state, then one cycle later the handshakes open
    chk("rst_in_ready",  64'(ifc.in_pixel_ready_o), 64'd0);
    chk("rst_row_valid", 64'(ifc.layer_row_valid_o), 64'd0);
    chk("rst_out_acc",   64'(ifc.layer_out_accept_o), 64'd0);
    chk("rst_out_valid", 64'(ifc.out_pixel_valid_o), 64'd0);
    chk("rst_done",      64'(ifc.frame_done_o), 64'd0);
    @(negedge clock_i);
    chk("open_in_ready", 64'(ifc.in_pixel_ready_o), 64'd1);
    chk("open_out_acc",  64'(ifc.layer_out_accept_o), 64'd1);

    // Immediate-accept full frame
    ifc.layer_row_accept_i = 1'b1;
    send_frame(784, stalls);
    repeat (3) @(negedge clock_i);
    chk("t1_stalls",   64'(stalls), 64'd0);
    chk("t1_issues",   64'(n_iss), 64'd28);
    chk("t1_r0_p5",    64'(iss_p5[0]), 64'd5);
    chk("t1_r1_p0",    64'(iss_p0[1]), 64'd28);
    chk("t1_r27_p0",   64'(iss_p0[27]), 64'd244);
    nl = 0;
    for (int k = 0; k < 28; k++) if (iss_last[k]) nl++;
    chk("t1_last_cnt", 64'(nl), 64'd1);
    chk("t1_last_r27", 64'(iss_last[27]), 64'd1);

    // Ingress backpressure: accept held low for 10 cycles in ISSUE
    ifc.layer_row_accept_i = 1'b0;
    for (int i = 0; i < 28; i++) begin
      send_px(8'(100 + i), 50, ok);
      if (!ok) stalls++;
    end
    chk("t2_stalls", 64'(stalls), 64'd0);
    chk("t2_valid",  64'(ifc.layer_row_valid_o), 64'd1);
    snap = ifc.layer_row_o;
    chk("t2_p0",     64'(snap[0][0]), 64'd100);
    chk("t2_p27",    64'(snap[27][0]), 64'd127);
    for (int c = 0; c < 10; c++) begin
      chk("t2_ready_low", 64'(ifc.in_pixel_ready_o), 64'd0);
      chk("t2_row_hold",  64'(ifc.layer_row_o === snap), 64'd1);
      @(negedge clock_i);
    end
    ifc.layer_row_accept_i = 1'b1;
    @(negedge clock_i);
    chk("t2_issued_valid", 64'(ifc.layer_row_valid_o), 64'd0);
    chk("t2_ready_back",   64'(ifc.in_pixel_ready_o), 64'd1);
    chk("t2_issue_cnt",    64'(n_iss), 64'd29);
    chk("t2_last0",        64'(iss_last[28]), 64'd0);

    // Egress serialization with last=1, then a non-final row
    egress_row(1'b1, beats, lasts, dones, order_ok, hold_ok, acc_ok, first_ok);
    chk("t3_first_valid", 64'(first_ok), 64'd1);
    chk("t3_beats",       64'(beats), 64'd28);
    chk("t3_order",       64'(order_ok), 64'd1);
    chk("t3_hold",        64'(hold_ok), 64'd1);
    chk("t3_acc_low",     64'(acc_ok), 64'd1);
    chk("t3_lasts",       64'(lasts), 64'd1);
    chk("t3_done",        64'(dones), 64'd1);
    egress_row(1'b0, beats, lasts, dones, order_ok, hold_ok, acc_ok, first_ok);
    chk("t3b_beats",      64'(beats), 64'd28);
    chk("t3b_lasts",      64'(lasts), 64'd0);
    chk("t3b_done",       64'(dones), 64'd0);

    // Reset mid-frame, then a clean frame
    for (int i = 0; i < 100; i++) send_px(8'hC8, 50, ok);
    reset_i = 1'b1;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    send_frame(784, stalls);
    repeat (3) @(negedge clock_i);
    chk("t4_stalls",   64'(stalls), 64'd0);
    chk("t4_issues",   64'(n_iss), 64'd28);
    chk("t4_r0_p0",    64'(iss_p0[0]), 64'd0);
    nl = 0;
    for (int k = 0; k < 28; k++) if (iss_last[k]) nl++;
    chk("t4_last_cnt", 64'(nl), 64'd1);
    chk("t4_last_r27", 64'(iss_last[27]), 64'd1);

    // Ingress capacity with the layer stalled
    reset_i = 1'b1;
    ifc.layer_row_accept_i = 1'b0;
    repeat (2) @(negedge clock_i);
    reset_i = 1'b0;
    @(negedge clock_i);
    acc = 0;
    for (int k = 0; k < 60; k++) begin
      send_px(8'(k), 30, ok);
      if (!ok) break;
      acc++;
    end
    ifc.layer_row_accept_i = 1'b1;
    repeat (4) @(negedge clock_i);
`ifdef CNN_SEQ_DOUBLE_BUFFER_EN
    chk("db_accepted", 64'(acc), 64'd56);
    chk("db_issues",   64'(n_iss), 64'd2);
    chk("db_r0_p0",    64'(iss_p0[0]), 64'd0);
    chk("db_r1_p0",    64'(iss_p0[1]), 64'd28);
    chk("db_r1_p5",    64'(iss_p5[1]), 64'd33);
    chk("db_b2b",      64'(iss_t[1] - iss_t[0]), 64'd10);
`else
    chk("sb_accepted", 64'(acc), 64'd28);
    chk("sb_issues",   64'(n_iss), 64'd1);
    chk("sb_r0_p5",    64'(iss_p5[0]), 64'd5);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
